alu_cond_unit: RTL and testbench
================================

// Module: alu_cond_unit
// PURPOSE
//  Consumer end of the ALU flag interface (n, c, z, v) emitted by the nbit_* ALU ops.
//  Holds the flags in a status register and evaluates 4-bit condition codes for
//  branch/predicated ops. Uses a req/ready + valid/ready handshake.
//  Sits between the ALU and the sequencer; a flag-write/eval hazard FSM guarantees
//  every evaluation sees the latest flags.
// PARAMETERS
//  len      4   width of taken-branch counter taken_cnt
// PORTS
//  clk         in   1    system clock, all state updates on rising edge
//  rst         in   1    asynchronous reset, active-high
//  flag_we     in   1    latch n_in/c_in/z_in/v_in into status register this cycle
//  n_in        in   1    ALU negative flag
//  c_in        in   1    ALU carry flag
//  z_in        in   1    ALU zero flag
//  v_in        in   1    ALU overflow flag
//  cond_req    in   1    request evaluation of cond_code
//  cond_code   in   4    condition selector (table below)
//  req_ready   out  1    unit accepts cond_req this cycle
//  resp_valid  out  1    taken is valid
//  resp_ready  in   1    sequencer consumes response
//  taken       out  1    condition result
//  flags       out  4    status register {n,c,z,v}
//  taken_cnt   out  len  saturating count of taken responses consumed
// BEHAVIOUR
//  Reset (async): flags=4'b0000, state=IDLE, req_ready=1, resp_valid=0, taken=0, taken_cnt=0.
//  Status register: on clk edge with flag_we=1, flags<={n_in,c_in,z_in,v_in}.
//   flag_we is honoured in every state.
//  Conditions (use registered flags):
//   0 EQ z | 1 NE !z | 2 CS c | 3 CC !c | 4 MI n | 5 PL !n | 6 VS v | 7 VC !v
//   8 HI c&!z | 9 LS !c|z | A GE n==v | B LT n!=v | C GT !z&(n==v)
//   D LE z|(n!=v) | E AL 1 | F NV 0
//  FSM, req_ready=1 only in IDLE:
//   IDLE : cond_req&!flag_we -> RESP; taken<=eval(flags, cond_code); latency 1 cycle.
//          cond_req&flag_we -> HAZARD; cond_code captured into code_q.
//   HAZARD: 1 stall cycle, so flags now holds the new values.
//          taken<=eval(flags, code_q); go RESP. Latency 2 cycles.
//   RESP : resp_valid=1; taken held stable until resp_ready=1.
//          resp_ready=1 -> IDLE; taken_cnt increments if taken=1.
//          taken_cnt saturates at 2^len-1, never wraps.
//          A flag_we during RESP does not alter the held taken.
//  cond_req while req_ready=0 is ignored; the requester must hold it.
//   There is no back-to-back accept in the cycle RESP exits: next accept is in IDLE.
//  Reset mid-operation: the pending request/response is dropped; flags are cleared.
//  No X on outputs after reset; cond_code outside IDLE/HAZARD capture is don't-care.
// TESTING
//  1 Reset: rst=1 mid-RESP -> resp_valid=0, flags=0000, taken_cnt=0, req_ready=1
//    (asynchronously, before the next edge).
//  2 Basic: flag_we with z=1, then cond_req EQ(0) -> next cycle resp_valid=1, taken=1.
//    Then NE(1) -> taken=0.
//  3 Hazard: flags=0000, same cycle flag_we{n=1,v=0} + cond_req LT(B).
//    -> req_ready=0 one cycle, resp_valid at cycle+2, taken=1.
//  4 Backpressure: resp_ready=0 for 3 cycles while flag_we changes flags.
//    -> taken stable, resp_valid held; resp_ready=1 -> IDLE next cycle.
//  5 Signed/unsigned: flags {n=0,c=1,z=0,v=1} -> HI=1, GE=0, GT=0, LE=1, AL=1, NV=0.
//    Sweep all 16 codes.
//  6 Saturation: len=4, 20 consumed AL responses -> taken_cnt=15, no wrap.
//    NV responses leave taken_cnt unchanged.

Source files
------------

// File: rtl/alu_cond_unit.sv
// Flag status register and condition-code evaluator for branch/predicated ops.
// A small FSM stalls one cycle when a flag write coincides with an evaluation request.
module alu_cond_unit #(
    parameter int len = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flag_we,
    input  logic           n_in,
    input  logic           c_in,
    input  logic           z_in,
    input  logic           v_in,
    input  logic           cond_req,
    input  logic [3:0]     cond_code,
    output logic           req_ready,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           taken,
    output logic [3:0]     flags,
    output logic [len-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAZARD = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [len-1:0] CNT_MAX = {len{1'b1}};

    // flags layout is {n, c, z, v}
    function automatic logic eval_cond(input logic [3:0] f, input logic [3:0] code);
        logic n, c, z, v, r;
        n = f[3];
        c = f[2];
        z = f[1];
        v = f[0];
        case (code)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = c;
            4'h3:    r = !c;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = c & !z;
            4'h9:    r = !c | z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z & (n == v);
            4'hD:    r = z | (n != v);
            4'hE:    r = 1'b1;
            4'hF:    r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    state_t         state_q, state_d;
    logic [3:0]     flags_q, flags_d;
    logic [3:0]     code_q, code_d;
    logic           taken_q, taken_d;
    logic           req_ready_q, req_ready_d;
    logic           resp_valid_q, resp_valid_d;
    logic [len-1:0] taken_cnt_q, taken_cnt_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        taken_d      = taken_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        taken_cnt_d  = taken_cnt_q;

        if (flag_we) begin
            flags_d = {n_in, c_in, z_in, v_in};
        end else begin
            flags_d = flags_q;
        end

        case (state_q)
            IDLE: begin
                if (cond_req && !flag_we) begin
                    taken_d      = eval_cond(flags_q, cond_code);
                    state_d      = RESP;
                    req_ready_d  = 1'b0;
                    resp_valid_d = 1'b1;
                end else if (cond_req && flag_we) begin
                    // evaluation waits one cycle so it sees the flags being written now
                    code_d       = cond_code;
                    state_d      = HAZARD;
                    req_ready_d  = 1'b0;
                    resp_valid_d = 1'b0;
                end else begin
                    state_d      = IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                end
            end
            HAZARD: begin
                taken_d      = eval_cond(flags_q, code_q);
                state_d      = RESP;
                req_ready_d  = 1'b0;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    if (taken_q && (taken_cnt_q != CNT_MAX)) begin
                        taken_cnt_d = taken_cnt_q + {{(len-1){1'b0}}, 1'b1};
                    end else begin
                        taken_cnt_d = taken_cnt_q;
                    end
                end else begin
                    state_d      = RESP;
                    req_ready_d  = 1'b0;
                    resp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                taken_d      = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            flags_q      <= 4'b0000;
            code_q       <= 4'h0;
            taken_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            taken_cnt_q  <= {len{1'b0}};
        end else begin
            state_q      <= state_d;
            flags_q      <= flags_d;
            code_q       <= code_d;
            taken_q      <= taken_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign taken      = taken_q;
    assign flags      = flags_q;
    assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_alu_cond_unit.sv
// Directed testbench for alu_cond_unit: reset, basic eval, hazard stall,
// backpressure, full condition sweep and counter saturation.
module tb_alu_cond_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       flag_we;
    logic       n_in, c_in, z_in, v_in;
    logic       cond_req;
    logic [3:0] cond_code;
    logic       req_ready;
    logic       resp_valid;
    logic       resp_ready;
    logic       taken;
    logic [3:0] flags;
    logic [3:0] taken_cnt;

    int errors = 0;
    int checks = 0;

    alu_cond_unit #(.len(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flag_we    (flag_we),
        .n_in       (n_in),
        .c_in       (c_in),
        .z_in       (z_in),
        .v_in       (v_in),
        .cond_req   (cond_req),
        .cond_code  (cond_code),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .taken      (taken),
        .flags      (flags),
        .taken_cnt  (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        flag_we = 1'b1;
        {n_in, c_in, z_in, v_in} = f;
        step();
        flag_we = 1'b0;
    endtask

    // issue one request with resp_ready high; returns the taken bit seen in RESP
    task automatic eval_once(input logic [3:0] code, output logic t, output logic v);
        cond_req  = 1'b1;
        cond_code = code;
        step();
        cond_req = 1'b0;
        t = taken;
        v = resp_valid;
        step();
    endtask

    logic [15:0] sweep_exp;
    logic        t_s, v_s;
    string       tag_s;

    initial begin
        rst = 1'b1;
        flag_we = 1'b0;
        {n_in, c_in, z_in, v_in} = 4'b0000;
        cond_req = 1'b0;
        cond_code = 4'h0;
        resp_ready = 1'b1;
        step();
        step();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_taken", {31'd0, taken}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'h0);
        chk("rst_cnt", {28'd0, taken_cnt}, 32'd0);
        rst = 1'b0;
        step();

        // basic: z=1 then EQ taken, NE not taken
        set_flags(4'b0010);
        chk("basic_flags", {28'd0, flags}, 32'h2);
        cond_req = 1'b1;
        cond_code = 4'h0;
        step();
        cond_req = 1'b0;
        chk("eq_valid", {31'd0, resp_valid}, 32'd1);
        chk("eq_taken", {31'd0, taken}, 32'd1);
        chk("eq_req_ready_low", {31'd0, req_ready}, 32'd0);
        step();
        chk("eq_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("eq_valid_drop", {31'd0, resp_valid}, 32'd0);
        chk("eq_cnt", {28'd0, taken_cnt}, 32'd1);
        eval_once(4'h1, t_s, v_s);
        chk("ne_valid", {31'd0, v_s}, 32'd1);
        chk("ne_taken", {31'd0, t_s}, 32'd0);
        chk("ne_cnt", {28'd0, taken_cnt}, 32'd1);

        // hazard: flag write and LT request in the same cycle
        set_flags(4'b0000);
        flag_we = 1'b1;
        {n_in, c_in, z_in, v_in} = 4'b1000;
        cond_req = 1'b1;
        cond_code = 4'hB;
        step();
        flag_we = 1'b0;
        cond_req = 1'b0;
        chk("hz_req_ready", {31'd0, req_ready}, 32'd0);
        chk("hz_valid_c1", {31'd0, resp_valid}, 32'd0);
        chk("hz_flags", {28'd0, flags}, 32'h8);
        step();
        chk("hz_valid_c2", {31'd0, resp_valid}, 32'd1);
        chk("hz_taken", {31'd0, taken}, 32'd1);
        step();
        chk("hz_cnt", {28'd0, taken_cnt}, 32'd2);
        chk("hz_idle", {31'd0, req_ready}, 32'd1);

        // backpressure: MI taken held while flags change underneath
        resp_ready = 1'b0;
        cond_req = 1'b1;
        cond_code = 4'h4;
        step();
        cond_req = 1'b0;
        chk("bp_valid0", {31'd0, resp_valid}, 32'd1);
        chk("bp_taken0", {31'd0, taken}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            flag_we = 1'b1;
            {n_in, c_in, z_in, v_in} = (i == 1) ? 4'b0111 : 4'b0000;
            step();
            chk($sformatf("bp_valid%0d", i + 1), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("bp_taken%0d", i + 1), {31'd0, taken}, 32'd1);
        end
        flag_we = 1'b0;
        chk("bp_flags", {28'd0, flags}, 32'h0);
        resp_ready = 1'b1;
        step();
        chk("bp_exit_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp_exit_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_cnt", {28'd0, taken_cnt}, 32'd3);

        // sweep all codes with n=0 c=1 z=0 v=1
        set_flags(4'b0101);
        sweep_exp = 16'h6966;
        for (int k = 0; k < 16; k++) begin
            eval_once(k[3:0], t_s, v_s);
            tag_s = $sformatf("sweep_code%0h", k);
            chk(tag_s, {30'd0, v_s, t_s}, {30'd0, 1'b1, sweep_exp[k]});
        end
        chk("sweep_cnt", {28'd0, taken_cnt}, 32'd11);

        // saturation: 20 AL responses, then NV
        for (int k = 0; k < 20; k++) begin
            eval_once(4'hE, t_s, v_s);
        end
        chk("sat_cnt", {28'd0, taken_cnt}, 32'd15);
        eval_once(4'hF, t_s, v_s);
        chk("nv_taken", {31'd0, t_s}, 32'd0);
        chk("nv_cnt", {28'd0, taken_cnt}, 32'd15);

        // asynchronous reset in the middle of RESP
        resp_ready = 1'b0;
        cond_req = 1'b1;
        cond_code = 4'hE;
        step();
        cond_req = 1'b0;
        chk("mid_valid_pre", {31'd0, resp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_flags", {28'd0, flags}, 32'h0);
        chk("mid_rst_cnt", {28'd0, taken_cnt}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_taken", {31'd0, taken}, 32'd0);
        resp_ready = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
